// File: rtl/linked_list_scheduler_pkg.sv
// Shared types and helpers for the linked_list scheduler.
package linked_list_scheduler_pkg;

    typedef enum logic [1:0] {
        LLS_INIT  = 2'd0,
        LLS_RUN   = 2'd1,
        LLS_DRAIN = 2'd2
    } sched_state_t;

    // Index width with a floor of one bit so single-list builds still have a port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/linked_list_scheduler_rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr wins; pointer state lives in the caller.
module rr_arbiter #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    int j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = W'(j);
            end
        end
    end

endmodule

// File: rtl/linked_list_scheduler.sv
// Sequences a shared-memory linked_list: RR push arbitration, RR pop scheduling,
// a registered dequeue port, linked_list reset sequencing and flush/drain.
module linked_list_scheduler
    import linked_list_scheduler_pkg::*;
#(
    parameter int NUM_ELEMS = 4,
    parameter int NUM_LISTS = 2,
    parameter int PTR_WIDTH = $clog2(NUM_ELEMS),
    parameter int LIST_W    = idx_width(NUM_LISTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_LISTS-1:0] enq_req,
    output logic [NUM_LISTS-1:0] enq_gnt,
    input  logic [NUM_LISTS-1:0] pop_en,
    input  logic                 flush,
    output logic                 flush_done,
    output logic                 deq_valid,
    input  logic                 deq_ready,
    output logic [LIST_W-1:0]    deq_list,
    output logic [PTR_WIDTH-1:0] deq_ptr,
    output logic                 ll_rst,
    output logic [NUM_LISTS-1:0] ll_push,
    output logic [NUM_LISTS-1:0] ll_pop,
    input  logic                 ll_full,
    input  logic [NUM_LISTS-1:0] ll_empty,
    input  logic [PTR_WIDTH-1:0] ll_popped
);

    sched_state_t         state, state_nxt;
    logic [LIST_W-1:0]    push_rr, pop_rr, push_idx, pop_idx;
    logic [NUM_LISTS-1:0] push_req, push_gnt, pop_req, pop_gnt;
    logic                 push_any, pop_any, slot_free, all_empty;

    function automatic logic [LIST_W-1:0] rr_next(input logic [LIST_W-1:0] i);
        return (int'(i) >= NUM_LISTS - 1) ? '0 : i + 1'b1;
    endfunction

    assign slot_free = !deq_valid || deq_ready;
    assign all_empty = &ll_empty;
    assign push_req  = (state == LLS_RUN && !ll_full) ? enq_req : '0;

    // DRAIN ignores the client mask so every list empties out.
    always_comb begin
        pop_req = '0;
        if (slot_free) begin
            if (state == LLS_RUN)        pop_req = ~ll_empty & pop_en;
            else if (state == LLS_DRAIN) pop_req = ~ll_empty;
        end
    end

    rr_arbiter #(.N(NUM_LISTS), .W(LIST_W)) u_push_arb (
        .req(push_req), .ptr(push_rr), .gnt(push_gnt), .idx(push_idx), .any(push_any)
    );

    rr_arbiter #(.N(NUM_LISTS), .W(LIST_W)) u_pop_arb (
        .req(pop_req), .ptr(pop_rr), .gnt(pop_gnt), .idx(pop_idx), .any(pop_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LLS_INIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LLS_INIT:  state_nxt = LLS_RUN;
            LLS_RUN:   if (flush) state_nxt = LLS_DRAIN;
            LLS_DRAIN: if (all_empty && slot_free) state_nxt = LLS_RUN;
            default:   state_nxt = LLS_INIT;
        endcase
    end

    always_comb begin
        ll_rst     = (state == LLS_INIT);
        flush_done = (state == LLS_DRAIN) && all_empty && slot_free;
        enq_gnt    = push_gnt;
        ll_push    = push_gnt;
        ll_pop     = pop_gnt;
    end

    // ll_popped is combinational on ll_pop, so it is captured in the pop cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_rr   <= '0;
            pop_rr    <= '0;
            deq_valid <= 1'b0;
            deq_list  <= '0;
            deq_ptr   <= '0;
        end else begin
            if (push_any) push_rr <= rr_next(push_idx);
            if (pop_any) begin
                pop_rr    <= rr_next(pop_idx);
                deq_valid <= 1'b1;
                deq_list  <= pop_idx;
                deq_ptr   <= ll_popped;
            end else if (deq_valid && deq_ready) begin
                deq_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_linked_list_scheduler.sv
// Bench: behavioural linked_list environment, a queue-level scheduler model compared every cycle,
// plus directed literal checks for reset, fill, dequeue order, backpressure, mask/flush and mid reset.
module tb_linked_list_scheduler;

    localparam int NE = 4;
    localparam int NL = 2;
    localparam int PW = 2;
    localparam int LW = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NL-1:0] enq_req = '0, pop_en = '0;
    logic          flush = 1'b0, deq_ready = 1'b0;
    logic [NL-1:0] enq_gnt, ll_push, ll_pop, ll_empty;
    logic          flush_done, deq_valid, ll_rst, ll_full;
    logic [LW-1:0] deq_list;
    logic [PW-1:0] deq_ptr, ll_popped;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    linked_list_scheduler #(.NUM_ELEMS(NE), .NUM_LISTS(NL)) dut (
        .clk(clk), .rst_n(rst_n), .enq_req(enq_req), .enq_gnt(enq_gnt), .pop_en(pop_en),
        .flush(flush), .flush_done(flush_done), .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_list(deq_list), .deq_ptr(deq_ptr), .ll_rst(ll_rst), .ll_push(ll_push), .ll_pop(ll_pop),
        .ll_full(ll_full), .ll_empty(ll_empty), .ll_popped(ll_popped)
    );

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- linked_list environment (free list + per-list FIFOs) ----------------
    int lst[NL][NE];
    int lcnt[NL];
    int fq[NE];
    int fcnt;

    initial begin
        fcnt = 0;
        for (int i = 0; i < NL; i++) lcnt[i] = 0;
    end

    always @(posedge clk) begin : ll_env
        int l_n[NL][NE];
        int c_n[NL];
        int f_n[NE];
        int fc_n;
        int pt;
        l_n = lst; c_n = lcnt; f_n = fq; fc_n = fcnt;
        if (ll_rst) begin
            for (int i = 0; i < NL; i++) c_n[i] = 0;
            for (int i = 0; i < NE; i++) f_n[i] = i;
            fc_n = NE;
        end else begin
            for (int i = 0; i < NL; i++) if (ll_push[i] && fc_n > 0) begin
                pt = f_n[0];
                for (int k = 0; k < NE - 1; k++) f_n[k] = f_n[k+1];
                fc_n--;
                l_n[i][c_n[i]] = pt;
                c_n[i]++;
            end
            for (int i = 0; i < NL; i++) if (ll_pop[i] && c_n[i] > 0) begin
                pt = l_n[i][0];
                for (int k = 0; k < NE - 1; k++) l_n[i][k] = l_n[i][k+1];
                c_n[i]--;
                f_n[fc_n] = pt;
                fc_n++;
            end
        end
        lst <= l_n; lcnt <= c_n; fq <= f_n; fcnt <= fc_n;
    end

    always_comb begin
        ll_full   = (fcnt == 0);
        ll_popped = '0;
        ll_empty  = '0;
        for (int i = 0; i < NL; i++) begin
            ll_empty[i] = (lcnt[i] == 0);
            if (ll_pop[i]) ll_popped = PW'(lst[i][0]);
        end
    end

    // ---------------- scheduler reference model ----------------
    // m_state: 0 = initialising, 1 = running, 2 = draining
    int m_state, m_prr, m_qrr, m_dl, m_dp;
    bit m_dv;
    int n_state, n_prr, n_qrr, n_dl, n_dp;
    bit n_dv;

    function automatic int rr_pick(input logic [NL-1:0] v, input int start);
        for (int k = 0; k < NL; k++) if (v[(start + k) % NL]) return (start + k) % NL;
        return -1;
    endfunction

    always @(negedge clk) begin : cmp
        logic [NL-1:0] e_gnt, e_pop, elig;
        bit e_fd, slot;
        int g, p, s, prr, qrr, dl, dp;
        bit dv;
        e_gnt = '0; e_pop = '0; e_fd = 1'b0;
        s = m_state; prr = m_prr; qrr = m_qrr; dv = m_dv; dl = m_dl; dp = m_dp;
        if (!rst_n) begin
            s = 0; prr = 0; qrr = 0; dv = 1'b0; dl = 0; dp = 0;
            chk("rst_ll_rst", ll_rst, 1);
        end else begin
            chk("m_ll_rst", ll_rst, (m_state == 0) ? 1 : 0);
            if (m_state == 1 && !ll_full) begin
                g = rr_pick(enq_req, m_prr);
                if (g >= 0) begin e_gnt[g] = 1'b1; prr = (g + 1) % NL; end
            end
            slot = !m_dv || deq_ready;
            if (m_dv && deq_ready) dv = 1'b0;
            if (m_state != 0 && slot) begin
                elig = ~ll_empty & ((m_state == 2) ? {NL{1'b1}} : pop_en);
                p = rr_pick(elig, m_qrr);
                if (p >= 0) begin
                    e_pop[p] = 1'b1; qrr = (p + 1) % NL;
                    dv = 1'b1; dl = p; dp = lst[p][0];
                end
            end
            case (m_state)
                0: s = 1;
                1: if (flush) s = 2;
                default: if (&ll_empty && slot) begin s = 1; e_fd = 1'b1; end
            endcase
        end
        chk("m_enq_gnt", enq_gnt, e_gnt);
        chk("m_ll_push", ll_push, e_gnt);
        chk("m_ll_pop", ll_pop, e_pop);
        chk("m_flush_done", flush_done, e_fd);
        chk("m_deq_valid", deq_valid, m_dv);
        chk("m_deq_list", deq_list, m_dl);
        chk("m_deq_ptr", deq_ptr, m_dp);
        n_state <= s; n_prr <= prr; n_qrr <= qrr; n_dv <= dv; n_dl <= dl; n_dp <= dp;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 0; m_prr <= 0; m_qrr <= 0; m_dv <= 1'b0; m_dl <= 0; m_dp <= 0;
        end else begin
            m_state <= n_state; m_prr <= n_prr; m_qrr <= n_qrr;
            m_dv <= n_dv; m_dl <= n_dl; m_dp <= n_dp;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_seq(input string tag);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk({tag, "_ll_rst_hi"}, ll_rst, 1);
        chk({tag, "_dv"}, deq_valid, 0);
        tick();
        @(negedge clk);
        chk({tag, "_ll_rst_lo"}, ll_rst, 0);
    endtask

    task automatic fill(input string tag, input bit check);
        int eg[5];
        eg[0] = 1; eg[1] = 2; eg[2] = 1; eg[3] = 2; eg[4] = 0;
        tick();
        enq_req = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (check) chk({tag, "_gnt"}, enq_gnt, eg[i]);
            if (check && i == 4) chk({tag, "_full"}, ll_full, 1);
            if (i < 4) tick();
        end
        tick();
        enq_req = 2'b00;
    endtask

    initial begin
        int el[4];
        int ep[4];
        int done_cnt;
        el[0] = 0; el[1] = 1; el[2] = 0; el[3] = 1;
        ep[0] = 0; ep[1] = 1; ep[2] = 2; ep[3] = 3;

        reset_seq("reset");
        fill("fill", 1'b1);

        pop_en = 2'b11; deq_ready = 1'b1;
        @(negedge clk);
        chk("deq_first_pop", ll_pop, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            chk("deq_valid", deq_valid, 1);
            chk("deq_list", deq_list, el[i]);
            chk("deq_ptr", deq_ptr, ep[i]);
        end
        tick();
        @(negedge clk);
        chk("deq_idle", deq_valid, 0);

        pop_en = 2'b00;
        fill("refill", 1'b0);
        pop_en = 2'b11; deq_ready = 1'b0;
        @(negedge clk);
        chk("bp_one_pop", ll_pop, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("bp_no_pop", ll_pop, 0);
            chk("bp_hold_valid", deq_valid, 1);
            chk("bp_hold_ptr", deq_ptr, 0);
        end

        tick();
        deq_ready = 1'b1; pop_en = 2'b10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mask_no_pop0", int'(ll_pop[0]), 0);
            tick();
        end
        chk("mask_list0_kept", int'(ll_empty[0]), 0);

        flush = 1'b1;
        tick();
        flush = 1'b0; enq_req = 2'b11;
        done_cnt = 0;
        for (int i = 0; i < 20 && done_cnt == 0; i++) begin
            @(negedge clk);
            chk("drain_no_gnt", enq_gnt, 0);
            if (flush_done) done_cnt++;
            tick();
        end
        chk("flush_done_seen", done_cnt, 1);
        @(negedge clk);
        chk("flush_done_pulse", flush_done, 0);
        enq_req = 2'b00;

        tick();
        enq_req = 2'b11;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_gnt", enq_gnt, 0);
        chk("midrst_dv", deq_valid, 0);
        chk("midrst_ll_rst", ll_rst, 1);
        enq_req = 2'b00;
        reset_seq("recover");

        for (int i = 0; i < 2000; i++) begin
            tick();
            enq_req   = NL'($urandom);
            pop_en    = NL'($urandom);
            deq_ready = ($urandom % 4) != 0;
            flush     = ($urandom % 40) == 0;
            if (i == 1000) rst_n = 1'b0;
            if (i == 1002) rst_n = 1'b1;
        end
        tick();
        flush = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
